demux_stream: RTL

- Parametrised 1-to-NUM_CH stream demultiplexer, the successor to the team's combinational 4-way demux.
- Routes each input word to the output channel chosen by in_sel, or to all channels in broadcast mode.
- Each output has a one-entry registered holding slot with a valid/ready handshake, so slow consumers stall only their own traffic.
- Sits between a single producer (e.g. a UART/bus front end) and NUM_CH independent consumers.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_slot.sv | 65 ++++++
 rtl/demux_stream.sv | 96 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: holding-slot state
// encoding and the select range check used by the top-level decode.
package demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // True when a (zero-extended) select value addresses an existing channel.
  function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned num_ch);
    return (sel < num_ch);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered holding slot with valid/ready handshake.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - write load_data into the slot this edge
//   load_data   - word to capture
//   out_ready   - consumer accepts the held word this edge
//   out_valid   - slot holds a word
//   out_data    - held word (stable while out_valid & !out_ready)
//   can_take    - slot can accept a load this edge (empty or draining)
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              can_take
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next state: a load while FULL only happens when draining, so it
  // replaces the outgoing word back-to-back.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          data_d  = load_data;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          data_d = load_data;
        end else if (out_ready) begin
          state_d = SLOT_EMPTY;
        end
      end
    endcase
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  assign can_take  = (state_q == SLOT_EMPTY) | out_ready;

endmodule

// File: rtl/demux_stream.sv
// 1-to-NUM_CH stream demultiplexer with per-channel holding slots,
// broadcast mode and a saturating counter of out-of-range drops.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   enable               - accept input when 1; slots drain regardless
//   in_valid/in_ready    - producer handshake (in_ready is combinational)
//   in_data, in_sel      - word and destination channel
//   in_bcast             - deliver word to every channel
//   out_valid/out_ready  - per-channel consumer handshake
//   out_data             - channel k at [k*DATA_W +: DATA_W]
//   drop_cnt             - words discarded for out-of-range select
//   busy                 - any slot holds a word
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     busy
);

  localparam int unsigned     SEL_SPAN = 2 ** SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0]   can_take;
  logic [NUM_CH-1:0]   load;
  logic [SEL_SPAN-1:0] can_take_ext;
  logic                sel_ok;
  logic                fire;
  logic                drop;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  assign sel_ok       = sel_in_range(32'(in_sel), NUM_CH);
  // Widened so every encodable select indexes a real bit.
  assign can_take_ext = SEL_SPAN'(can_take);

  // Acceptance: broadcast needs every slot, unicast only its target;
  // out-of-range words are always swallowed.
  always_comb begin
    in_ready = 1'b0;
    if (enable) begin
      if (in_bcast)    in_ready = &can_take;
      else if (sel_ok) in_ready = can_take_ext[in_sel];
      else             in_ready = 1'b1;
    end
  end

  assign fire = in_valid & in_ready;
  assign drop = fire & ~in_bcast & ~sel_ok;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    assign load[k] = fire & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));

    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*DATA_W +: DATA_W]),
      .can_take  (can_take[k])
    );
  end

  // Saturating drop counter.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != CNT_MAX)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
  assign busy     = |out_valid;

endmodule
